// File: rtl/uart_rx_param_if.sv
// Serial-line, tick, frame-format and result signals of the oversampling UART receiver.
// The receiver uses the slave modport; the line/tick source uses master.
interface uart_rx_param_if #(
  parameter int unsigned DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [1:0]      cfg_parity;
  logic            cfg_stop2;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            parity_err;
  logic            frame_err;
  logic            busy;

  modport master (
    output rx, s_tick, cfg_parity, cfg_stop2,
    input  rx_done_tick, dout, parity_err, frame_err, busy
  );

  modport slave (
    input  rx, s_tick, cfg_parity, cfg_stop2,
    output rx_done_tick, dout, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: LSB-first DBIT-bit frames, 1 or 2 stop bits, false-start rejection.
// Parity support (PARITY state, cfg_parity) is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int unsigned DBIT = 8,
  parameter int unsigned OVS  = 16
) (
  input logic            clk,
  input logic            reset,
  uart_rx_param_if.slave bus
);
  localparam int unsigned SCntW = $clog2(OVS);
  localparam int unsigned NCntW = $clog2(DBIT);
  localparam logic [SCntW-1:0] SMid  = SCntW'(OVS / 2 - 1);
  localparam logic [SCntW-1:0] SLast = SCntW'(OVS - 1);
  localparam logic [NCntW-1:0] NLast = NCntW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic             rx_meta_q, rx_s_q;
  state_e           state_q, state_d;
  logic [SCntW-1:0] s_q, s_d;
  logic [NCntW-1:0] n_q, n_d;
  logic             stop_n_q, stop_n_d;
  logic [DBIT-1:0]  b_q, b_d;
  logic             ferr_q, ferr_d;
  logic             stop2_q, stop2_d;
  logic             done_q, done_d;
  logic [DBIT-1:0]  dout_q, dout_d;
  logic             frame_err_q, frame_err_d;

`ifdef UART_RX_PARITY_EN
  logic [1:0] par_q, par_d;
  logic       perr_q, perr_d;
  logic       parity_err_q, parity_err_d;
  logic       par_on;

  assign par_on = (par_q == 2'b01) || (par_q == 2'b10);
`else
  logic unused_cfg_parity;

  assign unused_cfg_parity = ^bus.cfg_parity;
`endif

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    stop_n_d    = stop_n_q;
    b_d         = b_q;
    ferr_d      = ferr_q;
    stop2_d     = stop2_q;
    done_d      = 1'b0;
    dout_d      = dout_q;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    perr_d       = perr_q;
    parity_err_d = parity_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (bus.s_tick) begin
          if (s_q == SMid) begin
            s_d = '0;
            if (!rx_s_q) begin
              // Start bit confirmed at its centre: freeze the frame format for this frame.
              state_d = StData;
              n_d     = '0;
              stop2_d = bus.cfg_stop2;
              ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
              par_d  = bus.cfg_parity;
              perr_d = 1'b0;
`endif
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (bus.s_tick) begin
          if (s_q == SLast) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
              if (par_on) begin
                state_d = StParity;
              end else begin
                state_d  = StStop;
                stop_n_d = 1'b0;
              end
`else
              state_d  = StStop;
              stop_n_d = 1'b0;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bus.s_tick) begin
          if (s_q == SLast) begin
            // par_q[1] is set only for odd parity, which inverts the even check.
            perr_d   = ^b_q ^ rx_s_q ^ par_q[1];
            s_d      = '0;
            state_d  = StStop;
            stop_n_d = 1'b0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (bus.s_tick) begin
          if (s_q == SLast) begin
            s_d    = '0;
            ferr_d = ferr_q | ~rx_s_q;
            if (stop2_q && !stop_n_q) begin
              stop_n_d = 1'b1;
            end else begin
              state_d     = StIdle;
              done_d      = 1'b1;
              dout_d      = b_q;
              frame_err_d = ferr_q | ~rx_s_q;
`ifdef UART_RX_PARITY_EN
              parity_err_d = perr_q;
`endif
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      s_q         <= '0;
      n_q         <= '0;
      stop_n_q    <= 1'b0;
      b_q         <= '0;
      ferr_q      <= 1'b0;
      stop2_q     <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 2'b00;
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      stop_n_q    <= stop_n_d;
      b_q         <= b_d;
      ferr_q      <= ferr_d;
      stop2_q     <= stop2_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios plus randomized frames checked against a
// frame-level model. Build with or without UART_RX_PARITY_EN, same as the RTL.
module tb_uart_rx_param;
  localparam int unsigned TDIV = 3;
  localparam int unsigned OvsA = 16;
  localparam int unsigned DbitB = 7;
  localparam int unsigned OvsB = 8;
  localparam int unsigned BitA = OvsA * TDIV;
  localparam int unsigned BitB = OvsB * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam bit ParBuild = 1'b1;
`else
  localparam bit ParBuild = 1'b0;
`endif

  typedef struct {
    logic [8:0]  d;
    logic        pe;
    logic        fe;
    logic        busy;
    int unsigned t;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          wide = 0;
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;
  rec_t        qa[$];
  rec_t        qb[$];
  rec_t        ra, rb, nil, last;

  uart_rx_param_if #(.DBIT(8)) bus_a ();
  uart_rx_param_if #(.DBIT(DbitB)) bus_b ();

  uart_rx_param #(.DBIT(8), .OVS(OvsA)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  uart_rx_param #(.DBIT(DbitB), .OVS(OvsB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-clk tick every TDIV clocks, shared by both receivers.
  initial begin
    bus_a.s_tick = 1'b0;
    bus_b.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus_a.s_tick = (cyc % TDIV == 0);
      bus_b.s_tick = (cyc % TDIV == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus_a.rx_done_tick === 1'b1) begin
        ra.d = {1'b0, bus_a.dout}; ra.pe = bus_a.parity_err; ra.fe = bus_a.frame_err;
        ra.busy = bus_a.busy; ra.t = cyc;
        qa.push_back(ra);
        if (prev_a) wide++;
      end
      if (bus_b.rx_done_tick === 1'b1) begin
        rb.d = {2'b00, bus_b.dout}; rb.pe = bus_b.parity_err; rb.fe = bus_b.frame_err;
        rb.busy = bus_b.busy; rb.t = cyc;
        qb.push_back(rb);
        if (prev_b) wide++;
      end
      prev_a = bus_a.rx_done_tick;
      prev_b = bus_b.rx_done_tick;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=200000", cyc);
    $fatal(1, "timeout");
  end

  function automatic bit par_active(input logic [1:0] cfg);
    return ParBuild && (cfg == 2'b01 || cfg == 2'b10);
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_pbit(input logic [8:0] data, input int dbit, input logic [1:0] cfg);
    logic [8:0] mask;
    int ones;
    mask = (9'h1 << dbit) - 9'h1;
    ones = $countones(data & mask);
    return (cfg == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Even: total ones (data + parity) must be even; odd: must be odd.
  function automatic logic exp_perr(input logic [8:0] data, input int dbit, input logic [1:0] cfg,
                                    input logic pbit);
    logic [8:0] mask;
    int ones;
    if (!par_active(cfg)) return 1'b0;
    mask = (9'h1 << dbit) - 9'h1;
    ones = $countones(data & mask) + int'(pbit);
    return (ones % 2) != ((cfg == 2'b10) ? 1 : 0);
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit on_b, input logic [8:0] data, input int dbit,
                            input bit par_on, input logic pbit, input logic stop1,
                            input bit two_stop, input logic stop2v, input bit scramble,
                            output int unsigned t0);
    logic bits[$];
    int unsigned bper;
    bper = on_b ? BitB : BitA;
    bits.push_back(1'b0);
    for (int i = 0; i < dbit; i++) bits.push_back(data[i]);
    if (par_on) bits.push_back(pbit);
    bits.push_back(stop1);
    if (two_stop) bits.push_back(stop2v);
    while (cyc % TDIV != 1) @(negedge clk);
    t0 = cyc;
    foreach (bits[i]) begin
      if (on_b) bus_b.rx = bits[i];
      else bus_a.rx = bits[i];
      if (scramble && i == 1) begin
        bus_a.cfg_parity = 2'($urandom_range(0, 3));
        bus_a.cfg_stop2  = 1'($urandom_range(0, 1));
      end
      repeat (bper) @(negedge clk);
    end
    if (on_b) bus_b.rx = 1'b1;
    else bus_a.rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(4);
    total++; if (bus_a.rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_a.rx_done_tick); end
    total++; if (bus_a.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", bus_a.dout); end
    total++; if (bus_a.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", bus_a.parity_err); end
    total++; if (bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", bus_a.frame_err); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
    total++; if (bus_b.dout !== 7'h00) begin bad++; $display("FAIL reset_dout_b got=%h want=00", bus_b.dout); end
    reset = 1'b0;
    idle(4);
    last.d = 9'h000; last.pe = 1'b0; last.fe = 1'b0;
  endtask

  task automatic test_8n1();
    rec_t r;
    int unsigned t0, lo;
    bus_a.cfg_parity = 2'b00; bus_a.cfg_stop2 = 1'b0;
    qa.delete();
    send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t0);
    idle(BitA);
    r = nil; if (qa.size() > 0) r = qa[0];
    lo = 9 * BitA + BitA / 2;
    total++; if (qa.size() != 1) begin bad++; $display("FAIL 8n1_count got=%0d want=1", qa.size()); end
    total++; if (r.d !== 9'h0A5) begin bad++; $display("FAIL 8n1_dout got=%h want=0a5", r.d); end
    total++; if (r.pe !== 1'b0) begin bad++; $display("FAIL 8n1_perr got=%b want=0", r.pe); end
    total++; if (r.fe !== 1'b0) begin bad++; $display("FAIL 8n1_ferr got=%b want=0", r.fe); end
    total++; if (r.busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_at_done got=%b want=0", r.busy); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_after got=%b want=0", bus_a.busy); end
    total++;
    if (r.t - t0 < lo || r.t - t0 > lo + TDIV + 4) begin
      bad++; $display("FAIL 8n1_latency got=%0d want=%0d..%0d", r.t - t0, lo, lo + TDIV + 4);
    end
    last.d = 9'h0A5; last.pe = 1'b0; last.fe = 1'b0;
  endtask

  task automatic test_parity();
    logic [1:0] cfgs[4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    logic       pbits[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    rec_t r;
    int unsigned t0;
    logic ep;
    for (int k = 0; k < 4; k++) begin
      bus_a.cfg_parity = cfgs[k]; bus_a.cfg_stop2 = 1'b0;
      qa.delete();
      send_frame(1'b0, 9'h037, 8, par_active(cfgs[k]), pbits[k], 1'b1, 1'b0, 1'b1, 1'b0, t0);
      idle(BitA);
      ep = exp_perr(9'h037, 8, cfgs[k], pbits[k]);
      r = nil; if (qa.size() > 0) r = qa[0];
      total++; if (qa.size() != 1) begin bad++; $display("FAIL par%0d_count got=%0d want=1", k, qa.size()); end
      total++; if (r.d !== 9'h037) begin bad++; $display("FAIL par%0d_dout got=%h want=037", k, r.d); end
      total++; if (r.pe !== ep) begin bad++; $display("FAIL par%0d_perr got=%b want=%b", k, r.pe, ep); end
      total++; if (r.fe !== 1'b0) begin bad++; $display("FAIL par%0d_ferr got=%b want=0", k, r.fe); end
      last.d = 9'h037; last.pe = ep; last.fe = 1'b0;
    end
  endtask

  task automatic test_glitch();
    rec_t r;
    int unsigned t0;
    bus_a.cfg_parity = 2'b00; bus_a.cfg_stop2 = 1'b0;
    qa.delete();
    bus_a.rx = 1'b0;
    idle(4 * TDIV);
    bus_a.rx = 1'b1;
    idle(BitA);
    total++; if (qa.size() != 0) begin bad++; $display("FAIL glitch_pulse got=%0d want=0", qa.size()); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", bus_a.busy); end
    total++; if ({1'b0, bus_a.dout} !== last.d) begin bad++; $display("FAIL glitch_dout got=%h want=%h", bus_a.dout, last.d); end
    total++; if (bus_a.parity_err !== last.pe) begin bad++; $display("FAIL glitch_perr got=%b want=%b", bus_a.parity_err, last.pe); end
    total++; if (bus_a.frame_err !== last.fe) begin bad++; $display("FAIL glitch_ferr got=%b want=%b", bus_a.frame_err, last.fe); end
    send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t0);
    idle(BitA);
    r = nil; if (qa.size() > 0) r = qa[0];
    total++; if (qa.size() != 1) begin bad++; $display("FAIL glitch_next_count got=%0d want=1", qa.size()); end
    total++; if (r.d !== 9'h05A) begin bad++; $display("FAIL glitch_next_dout got=%h want=05a", r.d); end
    total++; if (r.pe !== 1'b0 || r.fe !== 1'b0) begin bad++; $display("FAIL glitch_next_flags got=%b%b want=00", r.pe, r.fe); end
    last.d = 9'h05A; last.pe = 1'b0; last.fe = 1'b0;
  endtask

  task automatic test_framing();
    logic s2[3] = '{1'b0, 1'b1, 1'b1};
    logic st1[3] = '{1'b0, 1'b1, 1'b0};
    logic st2[3] = '{1'b1, 1'b0, 1'b1};
    int   rel[3];
    rec_t r;
    int unsigned t0;
    bus_a.cfg_parity = 2'b00;
    for (int k = 0; k < 3; k++) begin
      bus_a.cfg_stop2 = s2[k];
      qa.delete();
      send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, st1[k], s2[k], st2[k], 1'b0, t0);
      idle(BitA);
      r = nil; if (qa.size() > 0) r = qa[0];
      rel[k] = int'(r.t) - int'(t0);
      total++; if (qa.size() != 1) begin bad++; $display("FAIL frm%0d_count got=%0d want=1", k, qa.size()); end
      total++; if (r.d !== 9'h03C) begin bad++; $display("FAIL frm%0d_dout got=%h want=03c", k, r.d); end
      total++; if (r.fe !== 1'b1) begin bad++; $display("FAIL frm%0d_ferr got=%b want=1", k, r.fe); end
      last.d = 9'h03C; last.pe = 1'b0; last.fe = 1'b1;
    end
    total++; if (rel[1] - rel[0] != int'(BitA)) begin bad++; $display("FAIL frm_stop2_delay got=%0d want=%0d", rel[1] - rel[0], BitA); end
  endtask

  task automatic test_reset_abort();
    rec_t r;
    int unsigned t0;
    logic [7:0] d = 8'h96;
    bus_a.cfg_parity = 2'b00; bus_a.cfg_stop2 = 1'b0;
    qa.delete();
    while (cyc % TDIV != 1) @(negedge clk);
    bus_a.rx = 1'b0;
    idle(BitA);
    for (int i = 0; i < 3; i++) begin bus_a.rx = d[i]; idle(BitA); end
    bus_a.rx = d[3];
    idle(BitA / 2);
    reset = 1'b1;
    idle(2);
    total++; if (bus_a.dout !== 8'h00) begin bad++; $display("FAIL abort_dout got=%h want=00", bus_a.dout); end
    total++; if (bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL abort_ferr got=%b want=0", bus_a.frame_err); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus_a.busy); end
    bus_a.rx = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2 * BitA);
    total++; if (qa.size() != 0) begin bad++; $display("FAIL abort_pulse got=%0d want=0", qa.size()); end
    send_frame(1'b0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t0);
    idle(BitA);
    r = nil; if (qa.size() > 0) r = qa[0];
    total++; if (qa.size() != 1) begin bad++; $display("FAIL abort_next_count got=%0d want=1", qa.size()); end
    total++; if (r.d !== 9'h0FF) begin bad++; $display("FAIL abort_next_dout got=%h want=0ff", r.d); end
    last.d = 9'h0FF; last.pe = 1'b0; last.fe = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] vals[2] = '{9'h07F, 9'h000};
    int unsigned t0[2];
    int unsigned flen;
    rec_t r;
    bus_b.cfg_parity = 2'b01; bus_b.cfg_stop2 = 1'b1;
    qb.delete();
    for (int k = 0; k < 2; k++)
      send_frame(1'b1, vals[k], 7, par_active(2'b01), good_pbit(vals[k], 7, 2'b01), 1'b1, 1'b1, 1'b1,
                 1'b0, t0[k]);
    idle(BitB * 2);
    flen = (1 + DbitB + (par_active(2'b01) ? 1 : 0) + 2) * BitB;
    total++; if (qb.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", qb.size()); end
    for (int k = 0; k < 2; k++) begin
      r = nil; if (qb.size() > k) r = qb[k];
      total++; if (r.d !== vals[k]) begin bad++; $display("FAIL b2b%0d_dout got=%h want=%h", k, r.d, vals[k]); end
      total++; if (r.pe !== 1'b0 || r.fe !== 1'b0) begin bad++; $display("FAIL b2b%0d_flags got=%b%b want=00", k, r.pe, r.fe); end
    end
    if (qb.size() == 2) begin
      total++;
      if (qb[1].t - qb[0].t != flen) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", qb[1].t - qb[0].t, flen); end
    end
  endtask

  task automatic test_random();
    rec_t r;
    int unsigned t0;
    logic [8:0] d;
    logic [1:0] cfg;
    logic two, pbit, s1, s2v, ep, ef;
    for (int k = 0; k < 24; k++) begin
      d    = 9'($urandom_range(0, 255));
      cfg  = 2'($urandom_range(0, 3));
      two  = 1'($urandom_range(0, 1));
      pbit = good_pbit(d, 8, cfg) ^ ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 5) != 0);
      s2v  = ($urandom_range(0, 5) != 0);
      ep   = exp_perr(d, 8, cfg, pbit);
      ef   = !s1 || (two && !s2v);
      bus_a.cfg_parity = cfg; bus_a.cfg_stop2 = two;
      qa.delete();
      send_frame(1'b0, d, 8, par_active(cfg), pbit, s1, two, s2v, 1'b1, t0);
      idle(BitA);
      r = nil; if (qa.size() > 0) r = qa[0];
      total++; if (qa.size() != 1) begin bad++; $display("FAIL rnd%0d_count got=%0d want=1", k, qa.size()); end
      total++; if (r.d !== d) begin bad++; $display("FAIL rnd%0d_dout got=%h want=%h", k, r.d, d); end
      total++; if (r.pe !== ep) begin bad++; $display("FAIL rnd%0d_perr got=%b want=%b", k, r.pe, ep); end
      total++; if (r.fe !== ef) begin bad++; $display("FAIL rnd%0d_ferr got=%b want=%b", k, r.fe, ef); end
    end
    total++; if (wide != 0) begin bad++; $display("FAIL pulse_width got=%0d want=0 wide pulses", wide); end
  endtask

  initial begin
    nil.d = 'x; nil.pe = 1'bx; nil.fe = 1'bx; nil.busy = 1'bx; nil.t = 0;
    bus_a.rx = 1'b1; bus_a.cfg_parity = 2'b00; bus_a.cfg_stop2 = 1'b0;
    bus_b.rx = 1'b1; bus_b.cfg_parity = 2'b00; bus_b.cfg_stop2 = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_framing();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, oversampling UART receiver for the serial front end of the UART–ALU datapath. It deserialises LSB-first frames of configurable data width with optional parity and one or two stop bits, and rejects false start bits. It reports parity and framing errors alongside each received word. It is driven by the shared baud-rate tick generator (`s_tick`, OVS ticks per bit) and feeds the interface FSM that loads ALU operands.

## Interface
- DBIT, 8, data bits per frame; legal 5..9
- OVS, 16, `s_tick` pulses per bit period; even, ≥ 8
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial line, asynchronous, idle high
- s_tick  in  1  oversampling enable, one clk wide
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
- cfg_stop2  in  1  1 = two stop bits, 0 = one stop bit
- rx_done_tick  out  1  one-clk pulse, frame complete
- dout  out  DBIT  received word, bit 0 = first data bit on the line
- parity_err  out  1  parity mismatch on last frame
- frame_err  out  1  a stop bit sampled low on last frame
- busy  out  1  high in any state other than IDLE

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`, reset value 1). All decisions use `rx_s`.
- Counters:
  - `s` tick counter is $clog2(OVS) bits.
  - `n` bit counter is $clog2(DBIT) bits.
  - `stop_n` is 1 bit.
- States:
  - IDLE: when `rx_s`==0, go to START with s=0.
  - START: on each `s_tick`, s++. When s==OVS/2-1 on an `s_tick`:
    - If `rx_s`==0, latch `cfg_parity`/`cfg_stop2` into shadow registers, then go to DATA with s=0, n=0.
    - Otherwise go to IDLE (glitch rejected, no flags, no pulse).
  - DATA: at s==OVS-1 on an `s_tick`, set s=0 and shift `b`={`rx_s`, b[DBIT-1:1]}.
    - When n==DBIT-1, go to PARITY if the shadow parity is even or odd, else go to STOP with stop_n=0.
    - Otherwise n++.
  - PARITY: at s==OVS-1 on an `s_tick`, capture `perr` = (^b ^ `rx_s`) for even, or ~(^b ^ `rx_s`) for odd. Then s=0 and go to STOP.
  - STOP: at s==OVS-1 on an `s_tick`, accumulate `ferr` |= ~`rx_s`, then:
    - If shadow stop2 is set and stop_n==0: stop_n=1, s=0, stay in STOP.
    - Otherwise complete the frame and go to IDLE.
- Frame completion happens regardless of `ferr`:
  - `dout`←b, `parity_err`←perr (0 if no parity), `frame_err`←ferr, pulse `rx_done_tick`.
- `perr` and `ferr` clear on START→DATA.
- `dout`, `parity_err` and `frame_err` hold until the next completion. A rejected glitch does not change them.
- `cfg_*` changes mid-frame do not affect the frame in progress.
- After completion, IDLE re-arms immediately. A low `rx_s` on the next clk starts a new frame.

## Timing
- Reset values: `rx_done_tick`=0, `dout`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state IDLE, all counters 0.
- Asserting `reset` mid-frame aborts the frame immediately with no pulse.
- `rx` to `rx_s` latency is 2 clk. A start edge sets `busy` on the 3rd clk edge after the `rx` fall.
- Data, parity and stop sampling occurs at mid-bit: OVS/2 + k·OVS ticks after the start edge was detected.
- `rx_done_tick` and the updated `dout`/flags are all registered.
  - They are visible the clk cycle after the edge that consumed the final stop-sample `s_tick`.
  - The pulse is exactly 1 clk wide.
- `busy` falls in the same cycle `rx_done_tick` rises.
- `s_tick` pulses arriving while in IDLE are ignored.
- Minimum frame length is (1 + DBIT + P + S)·OVS ticks, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits). The start bit counts as a full period because the next bit is sampled OVS ticks after the start-bit centre.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state and parity logic are compiled in.
  - `cfg_parity` is honoured.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; DATA goes directly to STOP.
  - `cfg_parity` is ignored and `parity_err` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- 8N1 frame, DBIT=8, OVS=16, byte 0xA5 → single `rx_done_tick`, `dout`=0xA5, `parity_err`=0, `frame_err`=0, `busy` low afterwards.
- Even parity (macro on, `cfg_parity`=01), byte 0x37 with parity bit 1 → `dout`=0x37, `parity_err`=0. Same byte with parity bit 0 → `parity_err`=1. Repeat with odd parity and the bits inverted.
- `rx` low for 4 ticks then high → no `rx_done_tick`, return to IDLE, `dout`/flags unchanged. A valid 0x5A frame immediately after is received correctly.
- Stop bit driven low on byte 0x3C → `rx_done_tick`=1, `dout`=0x3C, `frame_err`=1. With `cfg_stop2`=1 and the second stop bit low, `frame_err`=1 and the pulse comes one bit period later.
- `reset` asserted during the 4th data bit, then a clean 0xFF frame → no pulse for the aborted frame, outputs 0 during reset, `dout`=0xFF afterwards.
- DBIT=7, 7E2, back-to-back frames 0x7F, 0x00 → two pulses, exact values, no errors.
